mem_access_ctrl: RTL and testbench

Memory access controller between the datapath's MAR/MDR and the byte-wide RAM array. It answers the datapath's MFA/MFC handshake and serialises byte, halfword and word accesses into one-byte RAM cycles, with configurable wait states. Multi-byte values are assembled or split in big-endian (SPARC) order. Read data goes to the MDR input mux.

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_byte_lane.sv | 38 +++
 rtl/mem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory access controller:
//   - OP_SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as a word)
//   - controller FSM state encoding
//   - nbytes(): number of one-byte RAM slots an access of a given size needs
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Any encoding other than byte/halfword is a word access.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Datapath-side bus between the control unit / MAR / MDR and the memory
// access controller.
//   MFA      CU -> ctrl  memory function active (level request)
//   MOV_RW   CU -> ctrl  1 = load, 0 = store
//   OP_SIZE  CU -> ctrl  00 byte, 01 halfword, 1x word
//   SIGNED   CU -> ctrl  sign-extend byte/halfword loads
//   MAR      CU -> ctrl  byte address
//   DATA_IN  CU -> ctrl  store data from MDR
//   DATA_OUT ctrl -> CU  load result to MDR input mux
//   MFC      ctrl -> CU  memory function complete
//   MISALIGN ctrl -> CU  misaligned-access flag
// Modports: master = control unit side, slave = controller side.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if;

    logic        MFA;
    logic        MOV_RW;
    logic [1:0]  OP_SIZE;
    logic        SIGNED;
    logic [31:0] MAR;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        MFC;
    logic        MISALIGN;

    modport master (
        output MFA, MOV_RW, OP_SIZE, SIGNED, MAR, DATA_IN,
        input  DATA_OUT, MFC, MISALIGN
    );

    modport slave (
        input  MFA, MOV_RW, OP_SIZE, SIGNED, MAR, DATA_IN,
        output DATA_OUT, MFC, MISALIGN
    );

endinterface

// File: rtl/mem_byte_lane.sv
// -----------------------------------------------------------------------------
// mem_byte_lane
// Combinational big-endian byte shifter / extender.
//   data      in  32  store value
//   nb        in  3   access width in bytes (1, 2 or 4)
//   idx       in  2   byte slot index (0 = lowest address)
//   is_signed in  1   sign-extend byte/halfword loads
//   acc       in  32  assembled load bytes, last byte read in [7:0]
//   wbyte     out 8   store byte for slot idx
//   load      out 32  extended load result
// Slot 0 carries the most significant byte of an nb-byte value.
// -----------------------------------------------------------------------------
module mem_byte_lane (
    input  logic [31:0] data,
    input  logic [2:0]  nb,
    input  logic [1:0]  idx,
    input  logic        is_signed,
    input  logic [31:0] acc,
    output logic [7:0]  wbyte,
    output logic [31:0] load
);

    // Byte position inside data counted from bit 0: (nb - 1) - idx.
    logic [1:0] sh;

    assign sh    = 2'(nb - 3'd1) - idx;
    assign wbyte = 8'(data >> {sh, 3'b000});

    always_comb begin
        load = acc;
        case (nb)
            3'd1:    load = {{24{is_signed & acc[7]}},  acc[7:0]};
            3'd2:    load = {{16{is_signed & acc[15]}}, acc[15:0]};
            default: load = acc;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory access controller between the datapath MAR/MDR and a byte-wide RAM.
// Serialises byte/halfword/word accesses into one-byte RAM slots of
// WAIT_STATES+1 cycles each, big-endian, and answers the MFA/MFC handshake.
//
// Parameters: ADDR_W (RAM byte-address width), WAIT_STATES (0..15)
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   bus        slv  datapath handshake/bus (mem_access_ctrl_if.slave)
//   ram_addr   out  RAM byte address
//   ram_wdata  out  RAM write byte
//   ram_we     out  RAM write strobe (last cycle of a write slot)
//   ram_rdata  in   RAM read byte, combinational from ram_addr
//
// Build option: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word accesses do no RAM cycle and finish
//               with MFC=1, MISALIGN=1
//   undefined - low address bits are forced aligned, MISALIGN is tied to 0
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_access_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e            state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        nb_q;
    logic [1:0]        idx_q;
    logic [3:0]        wcnt;
    logic              rd_q;
    logic              sgn_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc;
    logic [31:0]       data_out_q;
    logic              mfc_q;
    logic              trap_q;
    logic              hold_q;

    logic [2:0]        nb_in;
    logic [1:0]        idx_nx;
    logic [ADDR_W-1:0] start_addr;
    logic              misaligned;
    logic [31:0]       lane_data;
    logic [2:0]        lane_nb;
    logic [1:0]        lane_idx;
    logic [7:0]        lane_wbyte;
    logic [31:0]       lane_load;
    logic              unused_mar_hi;

    assign nb_in  = nbytes(bus.OP_SIZE);
    assign idx_nx = idx_q + 2'd1;

    // Only the low ADDR_W bits address the RAM; the rest wrap away.
    assign unused_mar_hi = ^bus.MAR[31:ADDR_W];

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        start_addr = bus.MAR[ADDR_W-1:0];
        if (nb_in == 3'd2)      start_addr[0]   = 1'b0;
        else if (nb_in == 3'd4) start_addr[1:0] = 2'b00;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned   = (nb_in == 3'd2 && bus.MAR[0]) ||
                          (nb_in == 3'd4 && bus.MAR[1:0] != 2'b00);
    assign bus.MISALIGN = mfc_q & trap_q;
`else
    assign misaligned   = 1'b0;
    assign bus.MISALIGN = 1'b0;
`endif

    // In IDLE the lane looks at the live request so slot 0's byte can be
    // registered on the capture edge; later it prepares the next slot.
    assign lane_data = (state == ST_IDLE) ? bus.DATA_IN : wdata_q;
    assign lane_nb   = (state == ST_IDLE) ? nb_in : nb_q;
    assign lane_idx  = (state == ST_IDLE) ? 2'd0 : idx_nx;

    mem_byte_lane u_lane (
        .data      (lane_data),
        .nb        (lane_nb),
        .idx       (lane_idx),
        .is_signed (sgn_q),
        .acc       (acc),
        .wbyte     (lane_wbyte),
        .load      (lane_load)
    );

    assign bus.DATA_OUT = data_out_q;
    assign bus.MFC      = mfc_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            nb_q       <= 3'd1;
            idx_q      <= 2'd0;
            wcnt       <= 4'd0;
            rd_q       <= 1'b0;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            acc        <= '0;
            data_out_q <= '0;
            mfc_q      <= 1'b0;
            trap_q     <= 1'b0;
            hold_q     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.MFA) begin
                        addr_q  <= start_addr;
                        nb_q    <= nb_in;
                        rd_q    <= bus.MOV_RW;
                        sgn_q   <= bus.SIGNED;
                        wdata_q <= bus.DATA_IN;
                        idx_q   <= 2'd0;
                        wcnt    <= 4'd0;
                        acc     <= '0;
                        if (misaligned) begin
                            // One settling cycle in DONE before MFC/MISALIGN.
                            state  <= ST_DONE;
                            trap_q <= 1'b1;
                            hold_q <= 1'b1;
                        end else begin
                            state     <= ST_ACCESS;
                            ram_addr  <= start_addr;
                            ram_wdata <= lane_wbyte;
                            ram_we    <= !bus.MOV_RW && (WS == 4'd0);
                        end
                    end
                end

                ST_ACCESS: begin
                    if (wcnt == WS) begin
                        if (rd_q) acc <= {acc[23:0], ram_rdata};
                        if (idx_q == 2'(nb_q - 3'd1)) begin
                            state  <= ST_DONE;
                            ram_we <= 1'b0;
                        end else begin
                            idx_q     <= idx_nx;
                            wcnt      <= 4'd0;
                            ram_addr  <= addr_q + ADDR_W'(idx_nx);
                            ram_wdata <= lane_wbyte;
                            ram_we    <= !rd_q && (WS == 4'd0);
                        end
                    end else begin
                        wcnt   <= wcnt + 4'd1;
                        ram_we <= !rd_q && (wcnt + 4'd1 == WS);
                    end
                end

                ST_DONE: begin
                    if (hold_q) begin
                        hold_q <= 1'b0;
                    end else if (!mfc_q) begin
                        mfc_q <= 1'b1;
                        if (rd_q && !trap_q) data_out_q <= lane_load;
                    end else if (!bus.MFA) begin
                        mfc_q  <= 1'b0;
                        trap_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. Owns the byte RAM, keeps a shadow
// byte array as the reference memory and derives load results, write effects
// and handshake latency from the access rules with plain arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int ADDR_W   = 9;
    localparam int WS       = 1;
    localparam int RAM_SIZE = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              ram_we;
    logic              load_req = 1'b0;

    logic [7:0]  ram   [RAM_SIZE];
    logic [7:0]  model [RAM_SIZE];
    logic [31:0] exp_dout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl_if bif ();

    mem_access_ctrl #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .bus       (bif),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_addr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < RAM_SIZE; i++) ram[i] <= model[i];
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int base_of(input logic [31:0] mar, input int nb);
        return int'(mar & 32'(RAM_SIZE - 1)) & ~(nb - 1);
    endfunction

    function automatic logic [31:0] model_load(input int base, input int nb, input logic sg);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < nb; k++) v = (v << 8) | 32'(model[(base + k) % RAM_SIZE]);
        if (sg && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic int ram_diffs(input int lo, input int hi);
        int n;
        n = 0;
        for (int a = lo; a <= hi; a++) begin
            if (ram[(a + RAM_SIZE) % RAM_SIZE] !== model[(a + RAM_SIZE) % RAM_SIZE]) n++;
        end
        return n;
    endfunction

    // hold < 0: MFA drops right after capture; otherwise MFA stays high for
    // `hold` cycles after MFC before being released.
    task automatic access(input string tag, input logic rw, input logic [1:0] sz,
                          input logic sg, input logic [31:0] mar, input logic [31:0] din,
                          input int hold);
        int   nb, base, lat, we_cycles, we_pulses, good;
        int   exp_lat, exp_we, exp_pulses;
        logic prev_we, trap;
        nb   = nbytes_of(sz);
        base = base_of(mar, nb);
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = (nb == 2 && mar[0]) || (nb == 4 && mar[1:0] != 2'b00);
`endif
        @(negedge clk);
        bif.MFA     = 1'b1;
        bif.MOV_RW  = rw;
        bif.OP_SIZE = sz;
        bif.SIGNED  = sg;
        bif.MAR     = mar;
        bif.DATA_IN = din;
        @(posedge clk);
        #1;
        if (hold < 0) bif.MFA = 1'b0;
        bif.MAR     = $urandom;
        bif.DATA_IN = $urandom;
        lat = 0; we_cycles = 0; we_pulses = 0; prev_we = 1'b0;
        while (bif.MFC !== 1'b1 && lat < 100) begin
            if (ram_we) begin
                we_cycles++;
                if (!prev_we) we_pulses++;
            end
            prev_we = ram_we;
            @(posedge clk);
            #1;
            lat++;
        end
        exp_lat    = trap ? 2 : nb * (WS + 1) + 1;
        exp_we     = (rw || trap) ? 0 : nb;
        exp_pulses = (rw || trap) ? 0 : ((WS == 0) ? 1 : nb);
        if (!rw && !trap) begin
            for (int k = 0; k < nb; k++) model[(base + k) % RAM_SIZE] = 8'(din >> (8 * (nb - 1 - k)));
        end
        if (rw && !trap) exp_dout = model_load(base, nb, sg);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_we_cycles"}, we_cycles, exp_we);
        check({tag, "_we_pulses"}, we_pulses, exp_pulses);
        check({tag, "_data_out"}, bif.DATA_OUT, exp_dout);
        check({tag, "_misalign"}, bif.MISALIGN, trap);
        if (!rw) check({tag, "_ram"}, ram_diffs(base - 1, base + nb), 0);
        if (hold < 0) begin
            @(posedge clk);
            #1;
            check({tag, "_mfc_pulse"}, {bif.MFC, bif.MISALIGN}, 0);
        end else begin
            good = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (bif.MFC === 1'b1 && ram_we === 1'b0) good++;
            end
            check({tag, "_mfc_hold"}, good, hold);
            @(negedge clk);
            bif.MFA = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "_release"}, {bif.MFC, bif.MISALIGN}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < RAM_SIZE; i++) model[i] = 8'($urandom);
        model[0] = 8'h9C; model[1] = 8'h04; model[2] = 8'h40; model[3] = 8'h12;
        exp_dout    = 32'h0;
        rst_n       = 1'b0;
        bif.MFA     = 1'b0;
        bif.MOV_RW  = 1'b1;
        bif.OP_SIZE = 2'b00;
        bif.SIGNED  = 1'b0;
        bif.MAR     = 32'h0;
        bif.DATA_IN = 32'h0;
        load_req    = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("rst_data_out", bif.DATA_OUT, 32'h0);
        check("rst_ctrl", {bif.MFC, bif.MISALIGN, ram_we}, 3'b000);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        access("rd_word0",   1'b1, 2'b10, 1'b0, 32'h0,   32'h0,         1);
        access("rd_byte_s",  1'b1, 2'b00, 1'b1, 32'h0,   32'h0,         1);
        access("rd_byte_u",  1'b1, 2'b00, 1'b0, 32'h0,   32'h0,         1);
        access("rd_half_s",  1'b1, 2'b01, 1'b1, 32'h2,   32'h0,         1);
        access("wr_half6",   1'b0, 2'b01, 1'b0, 32'h6,   32'hA204_4012, 1);
        check("wr_half6_bytes", {ram[5] === model[5], ram[6], ram[7], ram[8] === model[8]},
              {1'b1, 8'h40, 8'h12, 1'b1});
        access("rd_hold",    1'b1, 2'b00, 1'b1, 32'h1,   32'h0,         6);
        access("rd_drop",    1'b1, 2'b10, 1'b0, 32'h4,   32'h0,        -1);
        access("rd_wrap",    1'b1, 2'b10, 1'b0, 32'h202, 32'h0,         1);
        access("wr_op11",    1'b0, 2'b11, 1'b0, 32'h10,  32'h1234_5678, 1);
        access("rd_op11",    1'b1, 2'b11, 1'b1, 32'h10,  32'h0,         0);

        // Reset in the middle of the third byte of a word store.
        @(negedge clk);
        bif.MFA     = 1'b1;
        bif.MOV_RW  = 1'b0;
        bif.OP_SIZE = 2'b10;
        bif.SIGNED  = 1'b0;
        bif.MAR     = 32'h20;
        bif.DATA_IN = 32'hDEAD_BEEF;
        @(posedge clk);
        repeat (2 * (WS + 1) + WS) @(posedge clk);
        #1;
        check("mid_wr_strobe", {ram_we, 1'(ram_addr), ram_wdata}, {1'b1, 1'b0, 8'hBE});
        check("mid_wr_addr", ram_addr, 9'h022);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_we", ram_we, 1'b0);
        check("async_rst_outs", {bif.MFC, bif.MISALIGN, bif.DATA_OUT}, 0);
        check("async_rst_ram_bus", {ram_addr, ram_wdata}, 0);
        model[32'h20] = 8'hDE;
        model[32'h21] = 8'hAD;
        exp_dout      = 32'h0;
        bif.MFA       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_partial_ram", ram_diffs(32'h1F, 32'h24), 0);
        access("post_rst_rd", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1);

        // Randomised accesses against the shadow memory.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] mar;
            case ($urandom_range(0, 2))
                0:       mar = 32'($urandom_range(0, 15));
                1:       mar = 32'h1F0 + 32'($urandom_range(0, 15));
                default: mar = $urandom;
            endcase
            access("rnd", 1'($urandom), 2'($urandom), 1'($urandom), mar, $urandom,
                   int'($urandom_range(0, 3)) - 1);
        end

        check("final_ram", ram_diffs(0, RAM_SIZE - 1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
